cache_repl_policy: RTL and testbench

Parametrised multi-policy victim selector for the L1 I$/D$ and future L2. It replaces the single-policy random replacer.
- Run-time selectable policies: tree pseudo-LRU, per-set FIFO (round-robin), and LFSR random.
- Invalid-way-first fill priority in every policy.
- Per-set state array with same-cycle write-to-read bypass.
- Sits beside the tag/data arrays in the cache and drives VictimWay to the way-select and write-enable logic.

---
 rtl/cache_repl_pkg.sv | 19 +
 rtl/repl_lfsr16.sv | 23 ++
 rtl/cache_repl_policy.sv | 146 ++++++++++++++
 tb/tb_cache_repl_policy.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_repl_pkg.sv
// Shared types and constants for the multi-policy cache victim selector.
// The LFSR seed and taps are also used by the L2 replacer.
package cache_repl_pkg;

  typedef enum logic [1:0] {
    REPL_PLRU   = 2'b00,
    REPL_RANDOM = 2'b01,
    REPL_FIFO   = 2'b10
  } repl_policy_e;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  // Feedback taps are bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int log_num_ways(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/repl_lfsr16.sv
// 16-bit Fibonacci LFSR for random victim selection.
// It shifts right and feeds the tap parity into bit 15.
module repl_lfsr16
  import cache_repl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] value
);

  // The LFSR steps only when enabled. A seed other than zero keeps it out of the all-zero lock-up state.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= {^(value & LFSR_TAPS), value[15:1]};
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/cache_repl_policy.sv
// Victim-way selector with tree-PLRU, FIFO and LFSR-random policies.
// Invalid ways are filled first. Per-set state is held with a write-to-read bypass.
module cache_repl_policy
  import cache_repl_pkg::*;
#(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          Policy,
  input  logic                                FlushStage,
  input  logic                                CacheEn,
  input  logic [NUMWAYS-1:0]                  HitWay,
  input  logic [NUMWAYS-1:0]                  ValidWay,
  input  logic [SETLEN-1:0]                   CacheSetData,
  input  logic [SETLEN-1:0]                   PAdr,
  input  logic                                LRUWriteEn,
  input  logic                                SetValid,
  input  logic                                InvalidateCache,
  output logic [NUMWAYS-1:0]                  VictimWay,
  output logic [log_num_ways(NUMWAYS)-1:0]    VictimWayEnc
);

  localparam int LOGW = log_num_ways(NUMWAYS);
  localparam int SW   = NUMWAYS - 1;
  localparam int IDXW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
  localparam logic [SETLEN:0] LINES = (SETLEN+1)'(NUMLINES);

  logic [SW-1:0]   mem [NUMLINES];
  logic [SW-1:0]   curr_state;
  logic [SW-1:0]   next_state;
  logic [SW-1:0]   plru_next;
  logic [SW-1:0]   rd_data;
  logic [15:0]     lfsr;
  logic [LOGW-1:0] hit_enc;
  logic [LOGW-1:0] upd_way;
  logic [LOGW-1:0] plru_victim;
  logic [LOGW-1:0] fifo_ptr;
  logic [LOGW-1:0] policy_victim;
  logic [LOGW-1:0] first_invalid;
  logic            any_invalid;
  logic            upd;
  logic            wr_en;
  logic            rd_in_range;
  logic            wr_in_range;
  logic            bypass;
  logic            unused_lfsr;

  assign upd         = LRUWriteEn & ~FlushStage;
  assign wr_en       = upd & (Policy != REPL_RANDOM);
  assign rd_in_range = ({1'b0, CacheSetData} < LINES);
  assign wr_in_range = ({1'b0, PAdr} < LINES);
  assign bypass      = wr_en & wr_in_range & (PAdr == CacheSetData);
  assign rd_data     = rd_in_range ? mem[CacheSetData[IDXW-1:0]] : '0;
  assign fifo_ptr    = curr_state[LOGW-1:0];
  assign upd_way     = SetValid ? VictimWayEnc : hit_enc;
  assign unused_lfsr = ^lfsr[15:LOGW];

  repl_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (upd & SetValid & ~InvalidateCache),
    .value (lfsr)
  );

  // Convert the one-hot hit vector to the index of the hit way.
  always_comb begin
    hit_enc = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (HitWay[i]) hit_enc = hit_enc | LOGW'(i);
      else           hit_enc = hit_enc;
    end
  end

  // Find the lowest-index invalid way.
  always_comb begin
    any_invalid   = ~&ValidWay;
    first_invalid = '0;
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!ValidWay[i]) first_invalid = LOGW'(i);
      else              first_invalid = first_invalid;
    end
  end

  // Walk the PLRU tree from the root. Each node bit selects which child to follow.
  always_comb begin
    int node;
    node = 0;
    for (int l = 0; l < LOGW; l++) begin
      node = 2 * node + 1 + int'(curr_state[SW-1-node]);
    end
    plru_victim = LOGW'(node - SW);
  end

  // Tree update: each node on the updated way's path is set to point away from that way.
  for (genvar l = 0; l < LOGW; l++) begin : g_lvl
    for (genvar p = 0; p < (1 << l); p++) begin : g_node
      localparam int N = (1 << l) - 1 + p;
      assign plru_next[SW-1-N] = (int'(upd_way >> (LOGW - l)) == p) ?
                                 ~upd_way[LOGW-1-l] : curr_state[SW-1-N];
    end
  end

  // Compute the next state and the victim for the selected policy. The reserved encoding acts as PLRU.
  always_comb begin
    next_state    = curr_state;
    policy_victim = plru_victim;
    case (Policy)
      REPL_FIFO: begin
        policy_victim = fifo_ptr;
        if (SetValid) next_state[LOGW-1:0] = fifo_ptr + LOGW'(1);
        else          next_state = curr_state;
      end
      REPL_RANDOM: begin
        policy_victim = lfsr[LOGW-1:0];
        next_state    = curr_state;
      end
      default: begin
        policy_victim = plru_victim;
        next_state    = plru_next;
      end
    endcase
  end

  // Drive the victim outputs. An invalid way overrides the policy choice.
  always_comb begin
    VictimWayEnc = any_invalid ? first_invalid : policy_victim;
    VictimWay    = '0;
    VictimWay[VictimWayEnc] = 1'b1;
  end

  // State array and read register. Reset and invalidate both clear them.
  always_ff @(posedge clk) begin
    if (reset || InvalidateCache) begin
      for (int i = 0; i < NUMLINES; i++) mem[i] <= '0;
      curr_state <= '0;
    end else begin
      if (wr_en && wr_in_range) mem[PAdr[IDXW-1:0]] <= next_state;
      if (CacheEn) curr_state <= bypass ? next_state : rd_data;
      else         curr_state <= curr_state;
    end
  end

endmodule

// File: tb/tb_cache_repl_policy.sv
// Randomised and directed bench for cache_repl_policy.
// It checks the DUT against a range-halving tree, per-set pointer and LFSR reference model.
module tb_cache_repl_policy;

  localparam int NW = 4;
  localparam int SL = 9;
  localparam int NL = 128;

  logic          clk = 1'b0;
  logic          reset, FlushStage, CacheEn, LRUWriteEn, SetValid, InvalidateCache;
  logic [1:0]    Policy;
  logic [NW-1:0] HitWay, ValidWay, VictimWay;
  logic [SL-1:0] CacheSetData, PAdr;
  logic [1:0]    VictimWayEnc;

  int compared   = 0;
  int mismatched = 0;

  bit          tree_m [NL][NW-1];
  int          ptr_m  [NL];
  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  cache_repl_policy #(.NUMWAYS(NW), .SETLEN(SL), .NUMLINES(NL)) dut (
    .clk(clk), .reset(reset), .Policy(Policy), .FlushStage(FlushStage), .CacheEn(CacheEn),
    .HitWay(HitWay), .ValidWay(ValidWay), .CacheSetData(CacheSetData), .PAdr(PAdr),
    .LRUWriteEn(LRUWriteEn), .SetValid(SetValid), .InvalidateCache(InvalidateCache),
    .VictimWay(VictimWay), .VictimWayEnc(VictimWayEnc)
  );

  task automatic model_clear(input bit seed);
    for (int s = 0; s < NL; s++) begin
      ptr_m[s] = 0;
      for (int n = 0; n < NW - 1; n++) tree_m[s][n] = 1'b0;
    end
    if (seed) lfsr_m = 16'h0001;
  endtask

  function automatic int model_victim(input int s, input logic [NW-1:0] valid, input logic [1:0] pol);
    int lo, hi, mid, node;
    for (int i = 0; i < NW; i++) if (!valid[i]) return i;
    if (pol == 2'b10) return ptr_m[s];
    if (pol == 2'b01) return int'(lfsr_m % 16'(NW));
    lo = 0; hi = NW; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (tree_m[s][node]) begin lo = mid; node = 2 * node + 2; end
      else                 begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  task automatic model_update(input int s, input int w, input bit fill, input logic [1:0] pol);
    int lo, hi, mid, node;
    if (pol == 2'b10) begin
      if (fill) ptr_m[s] = (ptr_m[s] + 1) % NW;
    end else if (pol != 2'b01) begin
      lo = 0; hi = NW; node = 0;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (w < mid) begin tree_m[s][node] = 1'b1; node = 2 * node + 1; hi = mid; end
        else         begin tree_m[s][node] = 1'b0; node = 2 * node + 2; lo = mid; end
      end
    end
    if (fill) lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  endtask

  task automatic drive_idle();
    LRUWriteEn = 1'b0; SetValid = 1'b0; HitWay = '0; FlushStage = 1'b0; InvalidateCache = 1'b0;
  endtask

  // One operation is a read cycle for set s, then an update cycle on s. The victim is sampled before the update edge.
  task automatic op(input int s, input bit wr, input bit fill, input int hit, input bit flush,
                    input logic [NW-1:0] valid, output logic [1:0] enc_o,
                    output logic [NW-1:0] way_o, output int exp_o);
    @(negedge clk);
    drive_idle();
    CacheEn = 1'b1; CacheSetData = SL'(s); PAdr = SL'(s); ValidWay = valid;
    @(posedge clk);
    @(negedge clk);
    LRUWriteEn = wr; SetValid = fill; FlushStage = flush;
    HitWay = fill ? '0 : NW'(1 << hit);
    #1;
    enc_o = VictimWayEnc; way_o = VictimWay;
    exp_o = model_victim(s, valid, Policy);
    @(posedge clk);
    if (wr && !flush) model_update(s, fill ? exp_o : hit, fill, Policy);
    #1 drive_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle(); reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear(1'b1);
  endtask

  task automatic do_invalidate();
    @(negedge clk);
    drive_idle(); InvalidateCache = 1'b1;
    @(posedge clk);
    #1 InvalidateCache = 1'b0;
    model_clear(1'b0);
  endtask

  task automatic test_reset();
    logic [NW-1:0] exp_w [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    ValidWay = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      Policy = 2'(p);
      #1;
      compared++;
      if (VictimWay !== exp_w[p]) begin
        mismatched++;
        $display("FAIL reset_victim pol=%0d got=%b exp=%b", p, VictimWay, exp_w[p]);
      end
    end
  endtask

  task automatic test_invalid_first();
    ValidWay = 4'b1011;
    for (int p = 0; p < 4; p++) begin
      Policy = 2'(p);
      #1;
      compared++;
      if (VictimWay !== 4'b0100 || VictimWayEnc !== 2'd2) begin
        mismatched++;
        $display("FAIL invalid_first pol=%0d got=%b/%0d exp=0100/2", p, VictimWay, VictimWayEnc);
      end
    end
    ValidWay = 4'b1111;
  endtask

  task automatic test_plru();
    logic [1:0] enc; logic [NW-1:0] vw; int ex;
    int hits [3] = '{0, 2, 1};
    Policy = 2'b00;
    do_invalidate();
    for (int i = 0; i < 3; i++) op(5, 1'b1, 1'b0, hits[i], 1'b0, 4'hF, enc, vw, ex);
    op(5, 1'b0, 1'b0, 0, 1'b0, 4'hF, enc, vw, ex);
    compared++;
    if (vw !== 4'b1000 || 2'(ex) !== enc) begin
      mismatched++;
      $display("FAIL plru_hits got=%b exp=1000 model=%0d", vw, ex);
    end
    do_invalidate();
    for (int i = 0; i < 3; i++) op(5, 1'b1, 1'b0, hits[i], 1'b1, 4'hF, enc, vw, ex);
    op(5, 1'b0, 1'b0, 0, 1'b0, 4'hF, enc, vw, ex);
    compared++;
    if (vw !== 4'b0001 || 2'(ex) !== enc) begin
      mismatched++;
      $display("FAIL plru_flush got=%b exp=0001 model=%0d", vw, ex);
    end
  endtask

  task automatic test_fifo();
    logic [1:0] enc; logic [NW-1:0] vw; int ex;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    Policy = 2'b10;
    do_invalidate();
    for (int i = 0; i < 5; i++) begin
      op(3, 1'b1, 1'b1, 0, 1'b0, 4'hF, enc, vw, ex);
      compared++;
      if (enc !== 2'(exp_seq[i]) || ex != exp_seq[i] || vw !== (4'b0001 << exp_seq[i])) begin
        mismatched++;
        $display("FAIL fifo_fill%0d got=%0d exp=%0d", i, enc, exp_seq[i]);
      end
      op(3, 1'b1, 1'b0, 2, 1'b0, 4'hF, enc, vw, ex);
    end
  endtask

  task automatic test_random();
    logic [1:0] enc; logic [NW-1:0] vw; int ex;
    int exp_seq [3] = '{1, 0, 0};
    do_reset();
    Policy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      op(2, 1'b1, 1'b1, 0, 1'b0, 4'hF, enc, vw, ex);
      compared++;
      if (enc !== 2'(exp_seq[i]) || ex != exp_seq[i]) begin
        mismatched++;
        $display("FAIL random_fill%0d got=%0d exp=%0d", i, enc, exp_seq[i]);
      end
      op(2, 1'b1, 1'b0, 3, 1'b0, 4'hF, enc, vw, ex);
    end
  endtask

  task automatic test_bypass();
    logic [1:0] enc; logic [NW-1:0] vw; int ex;
    Policy = 2'b00;
    do_invalidate();
    op(7, 1'b1, 1'b0, 0, 1'b0, 4'hF, enc, vw, ex);
    compared++;
    if (VictimWayEnc !== 2'd2 || model_victim(7, 4'hF, Policy) != 2) begin
      mismatched++;
      $display("FAIL bypass_same_edge got=%0d exp=2", VictimWayEnc);
    end
    @(negedge clk);
    CacheEn = 1'b0; CacheSetData = SL'(9);
    @(posedge clk); #1;
    compared++;
    if (VictimWayEnc !== 2'd2) begin
      mismatched++;
      $display("FAIL cacheen_hold got=%0d exp=2", VictimWayEnc);
    end
    @(negedge clk);
    CacheEn = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (VictimWayEnc !== 2'(model_victim(9, 4'hF, Policy)) || VictimWayEnc !== 2'd0) begin
      mismatched++;
      $display("FAIL cacheen_reload got=%0d exp=0", VictimWayEnc);
    end
  endtask

  task automatic test_invalidate_reset();
    logic [1:0] enc; logic [NW-1:0] vw; int ex;
    int hits [3] = '{0, 2, 1};
    Policy = 2'b00;
    do_invalidate();
    for (int i = 0; i < 3; i++) op(5, 1'b1, 1'b0, hits[i], 1'b0, 4'hF, enc, vw, ex);
    op(7, 1'b1, 1'b1, 0, 1'b0, 4'hF, enc, vw, ex);
    do_invalidate();
    for (int s = 5; s <= 7; s += 2) begin
      op(s, 1'b0, 1'b0, 0, 1'b0, 4'hF, enc, vw, ex);
      compared++;
      if (vw !== 4'b0001 || ex != 0) begin
        mismatched++;
        $display("FAIL invalidate_set%0d got=%b exp=0001", s, vw);
      end
    end
    Policy = 2'b01;
    #1;
    compared++;
    if (VictimWayEnc !== 2'(model_victim(5, 4'hF, Policy))) begin
      mismatched++;
      $display("FAIL invalidate_lfsr_hold got=%0d exp=%0d", VictimWayEnc, model_victim(5, 4'hF, Policy));
    end
    Policy = 2'b10;
    do_invalidate();
    op(3, 1'b1, 1'b1, 0, 1'b0, 4'hF, enc, vw, ex);
    @(negedge clk);
    CacheEn = 1'b1; CacheSetData = SL'(3); PAdr = SL'(3);
    LRUWriteEn = 1'b1; SetValid = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive_idle();
    model_clear(1'b1);
    op(3, 1'b0, 1'b0, 0, 1'b0, 4'hF, enc, vw, ex);
    compared++;
    if (enc !== 2'd0 || ex != 0) begin
      mismatched++;
      $display("FAIL reset_midfill_ptr got=%0d exp=0", enc);
    end
    Policy = 2'b01;
    #1;
    compared++;
    if (VictimWayEnc !== 2'd1) begin
      mismatched++;
      $display("FAIL reset_midfill_lfsr got=%0d exp=1", VictimWayEnc);
    end
  endtask

  task automatic test_random_mixed();
    logic [1:0] enc; logic [NW-1:0] vw, valid; int ex, s, hit; bit wr, fill, flush;
    for (int p = 0; p < 4; p++) begin
      Policy = 2'(p);
      do_invalidate();
      for (int k = 0; k < 60; k++) begin
        s     = ($urandom_range(0, 9) == 0) ? NL - 1 : int'($urandom_range(0, 7));
        valid = ($urandom_range(0, 4) == 0) ? NW'($urandom) : 4'hF;
        wr    = ($urandom_range(0, 3) != 0);
        fill  = 1'($urandom_range(0, 1));
        hit   = int'($urandom_range(0, NW - 1));
        flush = ($urandom_range(0, 7) == 0);
        op(s, wr, fill, hit, flush, valid, enc, vw, ex);
        compared++;
        if (enc !== 2'(ex) || vw !== (4'b0001 << ex)) begin
          mismatched++;
          $display("FAIL mixed pol=%0d k=%0d set=%0d got=%0d/%b exp=%0d", p, k, s, enc, vw, ex);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; Policy = 2'b00; CacheEn = 1'b1; ValidWay = 4'hF;
    CacheSetData = '0; PAdr = '0;
    drive_idle();
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    test_reset();
    test_invalid_first();
    test_plru();
    test_fifo();
    test_random();
    test_bypass();
    test_invalidate_reset();
    test_random_mixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
